// File: rtl/multiplier_if.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : multiplier_if                                              |
// | Description : Operand/result bundle for the pipelined sign-magnitude     |
// |               fixed-point multiplier.                                    |
// |               master : drives in_valid, a, b; receives out_valid, c,     |
// |                        overflow (the producer of operand pairs).         |
// |               slave  : the multiplier itself.                            |
// | Signals     : in_valid  - a/b carry a new operand pair this cycle        |
// |               a, b      - sign-magnitude operands, WIDTH bits            |
// |               out_valid - c/overflow carry a result this cycle           |
// |               c         - sign-magnitude product, WIDTH bits             |
// |               overflow  - product magnitude saturated                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface multiplier_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] c;
  logic             overflow;

  modport master (
    output in_valid,
    output a,
    output b,
    input  out_valid,
    input  c,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output out_valid,
    output c,
    output overflow
  );
endinterface
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : multiplier                                                 |
// | Description : Pipelined sign-magnitude fixed-point multiplier with FRAC  |
// |               fractional bits. The magnitude product is rescaled by      |
// |               2^-FRAC (truncation toward zero) and saturated to the      |
// |               largest magnitude when it does not fit. A zero magnitude   |
// |               is always emitted with a positive sign.                    |
// | Ports       : clk   - rising-edge clock                                  |
// |               rst_n - synchronous active-low reset, clears all stages    |
// |               bus   - multiplier_if.slave (in_valid/a/b in,              |
// |                       out_valid/c/overflow out, all outputs registered)  |
// | Pipeline    : edge k   : operands captured (stage 1)                     |
// |               edge k+1 : raw magnitude product captured (stage 2a)       |
// |               edge k+2 : scaled/saturated result captured (stage 2b)     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module multiplier #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 17
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  multiplier_if.slave bus
);

  // Magnitude excludes the sign bit; the raw product is twice that wide.
  localparam int MAG_W  = WIDTH - 1;
  localparam int PROD_W = 2 * MAG_W;
  // Lowest product bit that no longer fits the output magnitude after the
  // 2^-FRAC rescale.
  localparam int OVF_LSB = FRAC + MAG_W;

  localparam logic [MAG_W-1:0] C_MAG_MAX = {MAG_W{1'b1}};

  // ------------------------------------------------------------------------
  // Stage 1: operand capture
  // ------------------------------------------------------------------------
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= bus.in_valid;
      // Operands are only loaded with a valid pair so bubbles do not toggle
      // the multiplier array.
      if (bus.in_valid) begin
        r_s1_a <= bus.a;
        r_s1_b <= bus.b;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2a: unsigned magnitude product
  // ------------------------------------------------------------------------
  logic [MAG_W-1:0]  w_mag_a;
  logic [MAG_W-1:0]  w_mag_b;
  logic [PROD_W-1:0] w_prod;
  logic              w_sign_raw;

  always_comb begin
    w_mag_a    = r_s1_a[MAG_W-1:0];
    w_mag_b    = r_s1_b[MAG_W-1:0];
    // Both operands widened to the full product width so the multiply is
    // evaluated at PROD_W bits and nothing is lost.
    w_prod     = {{MAG_W{1'b0}}, w_mag_a} * {{MAG_W{1'b0}}, w_mag_b};
    w_sign_raw = r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1];
  end

  logic              r_s2_valid;
  logic              r_s2_sign;
  logic [PROD_W-1:0] r_s2_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sign  <= 1'b0;
      r_s2_prod  <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign <= w_sign_raw;
        r_s2_prod <= w_prod;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Stage 2b: rescale, saturate, zero-sign cleanup, output register
  // ------------------------------------------------------------------------
  logic             w_ovf;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;

  always_comb begin
    // Any set bit above the retained window means the scaled magnitude
    // needs more than MAG_W bits.
    w_ovf  = |r_s2_prod[PROD_W-1:OVF_LSB];
    w_mag  = w_ovf ? C_MAG_MAX : r_s2_prod[OVF_LSB-1:FRAC];
    // Negative zero never leaves the block: this also catches -0 operands
    // and products that truncate to zero.
    w_sign = r_s2_sign & (|w_mag);
  end

  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_overflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= r_s2_valid;
      // c/overflow keep the last result across bubbles.
      if (r_s2_valid) begin
        r_c        <= {w_sign, w_mag};
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_multiplier                                              |
// | Description : Self-checking bench for multiplier. Expected results are   |
// |               queued when a pair is driven and compared, together with   |
// |               their arrival cycle, when out_valid is seen.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_multiplier;

  localparam int WIDTH = 32;
  localparam int FRAC  = 17;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multiplier_if #(.WIDTH(WIDTH)) bus ();

  multiplier #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] c;
    logic        ovf;
    logic [31:0] due;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_pop;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] cyc      = 0;
  bit          started  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: full-width product, divide by 2^FRAC, clamp.
  function automatic void model(input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] ec, output logic eo);
    logic [63:0] p;
    logic [63:0] m;
    p = {33'b0, av[30:0]} * {33'b0, bv[30:0]};
    m = p / 64'd131072;
    if (m > 64'h7FFF_FFFF) begin
      eo = 1'b1;
      ec = {av[31] ^ bv[31], 31'h7FFF_FFFF};
    end else begin
      eo = 1'b0;
      ec = {(m != 0) & (av[31] ^ bv[31]), m[30:0]};
    end
  endfunction

  // Present one pair for one edge; optionally register its expected result.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ec, input logic eo, input bit push);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    if (push) sb.push_back('{c: ec, ovf: eo, due: cyc + 32'd3});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every out_valid must match the oldest expectation
  // and arrive exactly on its due cycle.
  always @(negedge clk) begin
    if (started) begin
      if (bus.out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check32("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
        end else begin
          e_pop = sb.pop_front();
          check32("result_c", bus.c, e_pop.c);
          check32("result_overflow", {31'b0, bus.overflow}, {31'b0, e_pop.ovf});
          check32("result_cycle", cyc, e_pop.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        check32("missing_result", {31'b0, bus.out_valid}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rc;
    logic        ro;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    idle(3);
    check32("reset_c", bus.c, 32'h0);
    check32("reset_overflow", {31'b0, bus.overflow}, 32'd0);
    check32("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    rst_n   = 1'b1;
    started = 1'b1;
    idle(2);

    // pi x e, then confirm the result holds through bubbles.
    drive(32'h0006487E, 32'h00056FC2, 32'h00111453, 1'b0, 1);
    idle(5);
    check32("hold_c", bus.c, 32'h00111453);
    check32("hold_overflow", {31'b0, bus.overflow}, 32'd0);
    check32("hold_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Sign handling.
    drive(32'h8006487E, 32'h00056FC2, 32'h80111453, 1'b0, 1);
    drive(32'h8006487E, 32'h80056FC2, 32'h00111453, 1'b0, 1);
    idle(1);

    // Zero, negative zero and underflow to zero.
    drive(32'h80000000, 32'h00020000, 32'h00000000, 1'b0, 1);
    drive(32'h80000001, 32'h00000001, 32'h00000000, 1'b0, 1);
    drive(32'h00000000, 32'h80056FC2, 32'h00000000, 1'b0, 1);
    idle(2);

    // Saturation, positive and negative.
    drive(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1);
    drive(32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1);
    // Largest magnitude that still fits: 0x7FFFFFFF x 1.0.
    drive(32'h7FFFFFFF, 32'h00020000, 32'h7FFFFFFF, 1'b0, 1);
    // Smallest overflow: 0x7FFFFFFF x (1.0 + 2^-17) carries one bit past the window.
    drive(32'h7FFFFFFF, 32'h00020001, 32'h7FFFFFFF, 1'b1, 1);
    idle(1);

    // Identity and back-to-back streaming.
    drive(32'h00020000, 32'h00056FC2, 32'h00056FC2, 1'b0, 1);
    drive(32'h00040000, 32'h0006487E, 32'h000C90FC, 1'b0, 1);

    // Back-to-back random pairs against the reference model.
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 != 0) begin
        ra[30:24] = 7'h0;
        rb[30:24] = 7'h0;
      end
      model(ra, rb, rc, ro);
      drive(ra, rb, rc, ro, 1);
    end

    // Drain, bounded.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check32("scoreboard_drained", sb.size(), 32'd0);
    idle(2);

    // Reset while two pairs are in flight: neither may emerge.
    drive(32'h0006487E, 32'h00056FC2, 32'h0, 1'b0, 0);
    drive(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 1'b0, 0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check32("midreset_c", bus.c, 32'h0);
    check32("midreset_overflow", {31'b0, bus.overflow}, 32'd0);
    check32("midreset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    idle(6);
    check32("midreset_quiet_c", bus.c, 32'h0);

    // Pipeline still works after the reset.
    drive(32'h00040000, 32'h0006487E, 32'h000C90FC, 1'b0, 1);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check32("post_reset_drained", sb.size(), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multiplier.md
Name: multiplier

Overview:
- Pipelined fixed-point multiplier for 32-bit sign-magnitude operands with 17 fractional bits.
- Used by the MLP feed-forward datapath for weight × activation products.
- Encoding:
  - bit 31 = sign (1 = negative).
  - bits 30:17 = integer magnitude.
  - bits 16:0 = fraction.
- Example: pi = 0x0006487E, e = 0x00056FC2.

Parameters:
- WIDTH, 32: total word width, including the sign bit.
- FRAC, 17: number of fractional bits; the product is rescaled by 2^-FRAC.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- in_valid, input, 1: a/b hold a new operand pair this cycle.
- a, input, WIDTH: multiplicand (sign-magnitude).
- b, input, WIDTH: multiplier (sign-magnitude).
- out_valid, output, 1: c/overflow hold a result this cycle.
- c, output, WIDTH: product (sign-magnitude, same Q format as the inputs).
- overflow, output, 1: the magnitude saturated for this result.

Behaviour:
- Single clock domain. All state updates on rising clk.
- Reset: when rst_n = 0 at a clock edge, all pipeline registers clear.
  - c = 0, overflow = 0, out_valid = 0.
  - In-flight operations are discarded.
  - Reset has priority over in_valid.
- Pipeline:
  - Stage 1 registers a, b and in_valid.
  - Stage 2 computes and registers c, overflow and out_valid.
- Latency: a pair sampled with in_valid = 1 at edge k appears at edge k+2 with out_valid = 1.
- Throughput: one new pair per cycle, no stalls, no backpressure.
- in_valid = 0: the bubble propagates and out_valid = 0 two cycles later.
  - c/overflow hold their previous values during bubbles (they are not cleared).
- Arithmetic:
  - sign = a[31] XOR b[31].
  - mag_a = a[30:0], mag_b = b[30:0] (31 bits each).
  - p = mag_a × mag_b, unsigned, 62 bits.
  - Scaled magnitude m = p >> FRAC, truncated toward zero. No rounding.
- Saturation:
  - If any bit of p above bit (FRAC+30) is set, m does not fit in 31 bits.
  - In that case the magnitude becomes 0x7FFFFFFF, overflow = 1, and the sign is kept.
  - Otherwise c[30:0] = p[FRAC+30:FRAC] and overflow = 0.
- Zero handling: if the result magnitude is 0, the sign bit is forced to 0. No negative zero is ever output.
  - This covers zero operands, negative-zero inputs and underflow to 0.
- Negative-zero inputs (0x80000000) are treated as zero.
- Purely combinational paths from inputs to outputs are not allowed; the outputs are registers.

Test Plan:
- Pi × e: a = 0x0006487E, b = 0x00056FC2, in_valid pulse.
  - Two cycles later: c = 0x00111453 (≈ 8.5397), overflow = 0, out_valid = 1 for one cycle.
- Sign:
  - a = 0x8006487E, b = 0x00056FC2 → c = 0x80111453.
  - Both operands negative → c = 0x00111453.
- Zero / negative zero:
  - a = 0x80000000, b = 0x00020000 → c = 0x00000000.
  - a = 0x80000001, b = 0x00000001 (underflow) → c = 0x00000000, overflow = 0.
- Saturation:
  - a = 0x7FFFFFFF, b = 0x7FFFFFFF → c = 0x7FFFFFFF, overflow = 1.
  - a = 0xFFFFFFFF, b = 0x7FFFFFFF → c = 0xFFFFFFFF, overflow = 1.
- Identity and streaming: back-to-back pairs (0x00020000 × 0x00056FC2) then (0x00040000 × 0x0006487E).
  - Results 0x00056FC2 then 0x000C90FC on consecutive cycles, both out_valid = 1.
- Reset mid-operation: issue two pairs, then hold rst_n = 0 for one edge on the cycle after the second pair.
  - c = 0, overflow = 0, out_valid = 0.
  - Neither pending result ever appears.
